// File: rtl/load_store_unit.sv
// Load/store unit: one outstanding request, alignment check, byte-lane steering,
// load sign/zero extension and an ACCESS-phase timeout.
module load_store_unit #(
   parameter int XLEN    = 32,
   parameter int ADDR_W  = 32,
   parameter int TIMEOUT = 16
) (
   input  logic                clk,
   input  logic                rst,
   input  logic                req_valid,
   output logic                req_ready,
   input  logic                req_we,
   input  logic [1:0]          req_size,
   input  logic                req_unsigned,
   input  logic [ADDR_W-1:0]   req_addr,
   input  logic [XLEN-1:0]     req_wdata,
   input  logic [4:0]          req_rd,
   output logic                resp_valid,
   output logic [XLEN-1:0]     resp_rdata,
   output logic [4:0]          resp_rd,
   output logic                resp_err,
   output logic                mem_read,
   output logic [XLEN/8-1:0]   mem_write,
   output logic [ADDR_W-1:0]   mem_addr,
   output logic [XLEN-1:0]     mem_wdata,
   input  logic [XLEN-1:0]     mem_rdata,
   input  logic                mem_ack
);

   // state  | meaning
   // IDLE   | ready for a request
   // ACCESS | memory request on the bus, waiting for mem_ack or timeout
   // RESP   | one-cycle response pulse

   localparam int NB    = XLEN / 8;
   localparam int OFF_W = $clog2(NB);
   localparam int IDX_W = $clog2(XLEN);
   localparam int CNT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
   localparam logic [7:0] XLEN_B = 8'(XLEN);

   typedef enum logic [1:0] {
      S_IDLE,
      S_ACCESS,
      S_RESP
   } state_t;

   state_t              state_q, state_d;
   logic                we_q, we_d;
   logic [1:0]          size_q, size_d;
   logic                uns_q, uns_d;
   logic [ADDR_W-1:0]   addr_q, addr_d;
   logic [XLEN-1:0]     wdata_q, wdata_d;
   logic [4:0]          rd_q, rd_d;
   logic                err_q, err_d;
   logic [XLEN-1:0]     rdata_q, rdata_d;
   logic [CNT_W-1:0]    cnt_q, cnt_d;

   logic                req_aligned;
   logic                req_legal;
   logic [OFF_W-1:0]    off;
   logic [XLEN-1:0]     rd_shifted;
   logic [7:0]          ld_bits;
   logic [XLEN-1:0]     ld_mask;
   logic                ld_sign;
   logic [XLEN-1:0]     ld_value;
   logic [NB-1:0]       size_mask;
   logic [NB-1:0]       st_strobe;
   logic [XLEN-1:0]     st_wdata;
   logic [ADDR_W-1:0]   addr_aligned;

   always_comb begin
      req_aligned = 1'b1;
      case (req_size)
         2'd1:    req_aligned = ~req_addr[0];
         2'd2:    req_aligned = ~|req_addr[1:0];
         2'd3:    req_aligned = ~|req_addr[2:0];
         default: req_aligned = 1'b1;
      endcase
      req_legal = req_aligned && !(req_size == 2'd3 && XLEN == 32);
   end

   // Lane steering is computed from the registered request so mem_* stay stable
   always_comb begin
      off          = addr_q[OFF_W-1:0];
      addr_aligned = {addr_q[ADDR_W-1:OFF_W], {OFF_W{1'b0}}};
      rd_shifted   = mem_rdata >> {off, 3'b000};
      ld_bits      = 8'd8 << size_q;
      if (ld_bits > XLEN_B) ld_bits = XLEN_B;
      ld_mask      = ~({XLEN{1'b1}} << ld_bits);
      ld_sign      = rd_shifted[IDX_W'(ld_bits - 8'd1)] & ~uns_q;
      ld_value     = (rd_shifted & ld_mask) | ({XLEN{ld_sign}} & ~ld_mask);
      case (size_q)
         2'd0:    size_mask = NB'(1);
         2'd1:    size_mask = NB'(3);
         2'd2:    size_mask = NB'(15);
         default: size_mask = {NB{1'b1}};
      endcase
      st_strobe    = size_mask << off;
      st_wdata     = wdata_q << {off, 3'b000};
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= S_IDLE;
         we_q    <= 1'b0;
         size_q  <= 2'd0;
         uns_q   <= 1'b0;
         addr_q  <= '0;
         wdata_q <= '0;
         rd_q    <= '0;
         err_q   <= 1'b0;
         rdata_q <= '0;
         cnt_q   <= '0;
      end else begin
         state_q <= state_d;
         we_q    <= we_d;
         size_q  <= size_d;
         uns_q   <= uns_d;
         addr_q  <= addr_d;
         wdata_q <= wdata_d;
         rd_q    <= rd_d;
         err_q   <= err_d;
         rdata_q <= rdata_d;
         cnt_q   <= cnt_d;
      end
   end

   always_comb begin
      state_d    = state_q;
      we_d       = we_q;
      size_d     = size_q;
      uns_d      = uns_q;
      addr_d     = addr_q;
      wdata_d    = wdata_q;
      rd_d       = rd_q;
      err_d      = err_q;
      rdata_d    = rdata_q;
      cnt_d      = cnt_q;
      req_ready  = 1'b0;
      mem_read   = 1'b0;
      mem_write  = '0;
      mem_addr   = '0;
      mem_wdata  = '0;
      resp_valid = 1'b0;
      resp_rdata = '0;
      resp_rd    = '0;
      resp_err   = 1'b0;
      case (state_q)
         S_IDLE: begin
            req_ready = 1'b1;
            if (req_valid) begin
               we_d    = req_we;
               size_d  = req_size;
               uns_d   = req_unsigned;
               addr_d  = req_addr;
               wdata_d = req_wdata;
               rd_d    = req_rd;
               rdata_d = '0;
               cnt_d   = CNT_W'(TIMEOUT - 1);
               err_d   = ~req_legal;
               state_d = req_legal ? S_ACCESS : S_RESP;
            end
         end
         S_ACCESS: begin
            mem_read  = ~we_q;
            mem_write = we_q ? st_strobe : '0;
            mem_addr  = addr_aligned;
            mem_wdata = we_q ? st_wdata : '0;
            // ack wins even in the terminal count cycle
            if (mem_ack) begin
               err_d   = 1'b0;
               rdata_d = we_q ? '0 : ld_value;
               state_d = S_RESP;
            end else if (cnt_q == '0) begin
               err_d   = 1'b1;
               rdata_d = '0;
               state_d = S_RESP;
            end else begin
               cnt_d = cnt_q - 1'b1;
            end
         end
         S_RESP: begin
            resp_valid = 1'b1;
            resp_rdata = rdata_q;
            resp_rd    = we_q ? 5'd0 : rd_q;
            resp_err   = err_q;
            state_d    = S_IDLE;
         end
         default: state_d = S_IDLE;
      endcase
   end

endmodule

// File: tb/tb_load_store_unit.sv
// Bench for load_store_unit: directed corner cases plus randomized traffic
// against an arithmetic reference model; 32-bit and 64-bit instances.
module tb_load_store_unit;

   localparam int TO = 4;

   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   logic        req_valid = 0, req_ready, req_we = 0, req_unsigned = 0;
   logic [1:0]  req_size = 0;
   logic [31:0] req_addr = 0, req_wdata = 0;
   logic [4:0]  req_rd = 0;
   logic        resp_valid, resp_err;
   logic [31:0] resp_rdata;
   logic [4:0]  resp_rd;
   logic        mem_read, mem_ack = 0;
   logic [3:0]  mem_write;
   logic [31:0] mem_addr, mem_wdata, mem_rdata = 0;

   logic        req_valid64 = 0, req_ready64, req_we64 = 0, req_unsigned64 = 0;
   logic [1:0]  req_size64 = 0;
   logic [31:0] req_addr64 = 0;
   logic [63:0] req_wdata64 = 0;
   logic [4:0]  req_rd64 = 0;
   logic        resp_valid64, resp_err64;
   logic [63:0] resp_rdata64;
   logic [4:0]  resp_rd64;
   logic        mem_read64, mem_ack64 = 0;
   logic [7:0]  mem_write64;
   logic [31:0] mem_addr64;
   logic [63:0] mem_wdata64, mem_rdata64 = 0;

   load_store_unit #(.XLEN(32), .ADDR_W(32), .TIMEOUT(TO)) dut (
      .clk(clk), .rst(rst),
      .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
      .req_size(req_size), .req_unsigned(req_unsigned), .req_addr(req_addr),
      .req_wdata(req_wdata), .req_rd(req_rd),
      .resp_valid(resp_valid), .resp_rdata(resp_rdata), .resp_rd(resp_rd),
      .resp_err(resp_err),
      .mem_read(mem_read), .mem_write(mem_write), .mem_addr(mem_addr),
      .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .mem_ack(mem_ack)
   );

   load_store_unit #(.XLEN(64), .ADDR_W(32), .TIMEOUT(TO)) dut64 (
      .clk(clk), .rst(rst),
      .req_valid(req_valid64), .req_ready(req_ready64), .req_we(req_we64),
      .req_size(req_size64), .req_unsigned(req_unsigned64), .req_addr(req_addr64),
      .req_wdata(req_wdata64), .req_rd(req_rd64),
      .resp_valid(resp_valid64), .resp_rdata(resp_rdata64), .resp_rd(resp_rd64),
      .resp_err(resp_err64),
      .mem_read(mem_read64), .mem_write(mem_write64), .mem_addr(mem_addr64),
      .mem_wdata(mem_wdata64), .mem_rdata(mem_rdata64), .mem_ack(mem_ack64)
   );

   int n_cmp = 0;
   int n_fail = 0;

   // observations gathered by run32
   int          o_lat, o_acc, o_rdc;
   logic [31:0] o_addr, o_wdata, o_rdata;
   logic [3:0]  o_strobe;
   logic [4:0]  o_rd;
   logic        o_err, o_stable, o_quiet, o_pulse, o_ready, o_first_read;

   // Reference model: plain arithmetic on the request
   function automatic bit legal32(input logic [1:0] size, input logic [31:0] addr);
      return (size != 2'd3) && ((addr % (32'd1 << size)) == 0);
   endfunction

   function automatic logic [31:0] exp_load(input logic [31:0] mrd, input logic [31:0] addr,
                                            input logic [1:0] size, input logic uns);
      longint unsigned v, m;
      int bits;
      bits = 8 << size;
      v = 64'(mrd) >> (8 * (addr % 4));
      m = (64'd1 << bits) - 64'd1;
      v = v & m;
      if (!uns && v[bits-1]) v = v | ~m;
      return v[31:0];
   endfunction

   // Drives one request at the 32-bit unit; waits<0 means never ack.
   // Entered and left #1 after a rising edge with the unit idle.
   task automatic run32(input logic we, input logic [1:0] size, input logic uns,
                        input logic [31:0] addr, input logic [31:0] wdata,
                        input logic [4:0] rd, input int waits, input logic [31:0] mrd);
      int acc;
      acc = 0; o_lat = -1; o_rdc = 0; o_stable = 1; o_quiet = 1; o_pulse = 0;
      o_addr = 0; o_strobe = 0; o_wdata = 0; o_rdata = 0; o_rd = 0; o_err = 0;
      o_first_read = 0;
      o_ready = req_ready;
      req_valid = 1; req_we = we; req_size = size; req_unsigned = uns;
      req_addr = addr; req_wdata = wdata; req_rd = rd;
      @(posedge clk); #1;
      req_valid = 0;
      mem_rdata = mrd;
      for (int cyc = 1; cyc <= 30; cyc++) begin
         if (resp_valid) begin
            o_lat = cyc; o_rdata = resp_rdata; o_rd = resp_rd; o_err = resp_err;
            break;
         end
         if (resp_rdata !== 0 || resp_rd !== 0 || resp_err !== 0) o_quiet = 0;
         if (mem_read || mem_write != 0) begin
            if (acc == 0) begin
               o_addr = mem_addr; o_strobe = mem_write; o_wdata = mem_wdata;
               o_first_read = mem_read;
            end else if (mem_addr !== o_addr || mem_write !== o_strobe ||
                         mem_wdata !== o_wdata || mem_read !== o_first_read) begin
               o_stable = 0;
            end
            if (mem_read) o_rdc++;
            mem_ack = (waits >= 0 && acc == waits);
            acc++;
         end
         @(posedge clk); #1;
         mem_ack = 0;
      end
      o_acc = acc;
      @(posedge clk); #1;
      o_pulse = !resp_valid && req_ready;
   endtask

   task automatic test_reset;
      #2;
      n_cmp++; if (req_ready !== 1'b1) begin n_fail++; $display("FAIL reset_ready: got %b want 1", req_ready); end
      n_cmp++; if (mem_read !== 1'b0 || mem_write !== 4'h0) begin n_fail++; $display("FAIL reset_mem: got rd=%b wr=%h want 0", mem_read, mem_write); end
      n_cmp++; if (resp_valid !== 0 || resp_rdata !== 0 || resp_rd !== 0 || resp_err !== 0) begin n_fail++; $display("FAIL reset_resp: got v=%b d=%h rd=%0d e=%b want 0", resp_valid, resp_rdata, resp_rd, resp_err); end
      n_cmp++; if (mem_addr !== 0 || mem_wdata !== 0) begin n_fail++; $display("FAIL reset_bus: got a=%h w=%h want 0", mem_addr, mem_wdata); end
      @(negedge clk); rst = 0;
      @(posedge clk); #1;
   endtask

   task automatic test_load_byte;
      run32(1'b0, 2'd0, 1'b0, 32'h103, 32'h0, 5'd11, 0, 32'h80123456);
      n_cmp++; if (o_addr !== 32'h100) begin n_fail++; $display("FAIL lb_addr: got %h want 00000100", o_addr); end
      n_cmp++; if (o_rdata !== 32'hFFFFFF80) begin n_fail++; $display("FAIL lb_rdata: got %h want ffffff80", o_rdata); end
      n_cmp++; if (o_lat !== 2) begin n_fail++; $display("FAIL lb_latency: got %0d want 2", o_lat); end
      n_cmp++; if (o_rd !== 5'd11 || o_err !== 1'b0) begin n_fail++; $display("FAIL lb_tag: got rd=%0d err=%b want 11/0", o_rd, o_err); end
      n_cmp++; if (o_ready !== 1'b1 || o_pulse !== 1'b1) begin n_fail++; $display("FAIL lb_handshake: got ready=%b pulse=%b want 1/1", o_ready, o_pulse); end
   endtask

   task automatic test_store_half;
      run32(1'b1, 2'd1, 1'b0, 32'h102, 32'h00001234, 5'd7, 1, 32'hDEADBEEF);
      n_cmp++; if (o_strobe !== 4'b1100) begin n_fail++; $display("FAIL sh_strobe: got %b want 1100", o_strobe); end
      n_cmp++; if (o_wdata[31:16] !== 16'h1234) begin n_fail++; $display("FAIL sh_wdata: got %h want 1234", o_wdata[31:16]); end
      n_cmp++; if (o_rd !== 5'd0 || o_err !== 1'b0 || o_rdata !== 0) begin n_fail++; $display("FAIL sh_resp: got rd=%0d err=%b d=%h want 0/0/0", o_rd, o_err, o_rdata); end
      n_cmp++; if (o_rdc !== 0 || o_lat !== 3) begin n_fail++; $display("FAIL sh_timing: got reads=%0d lat=%0d want 0/3", o_rdc, o_lat); end
   endtask

   task automatic test_misaligned;
      run32(1'b0, 2'd2, 1'b0, 32'h102, 32'h0, 5'd3, 0, 32'h11111111);
      n_cmp++; if (o_err !== 1'b1 || o_lat !== 1) begin n_fail++; $display("FAIL misalign: got err=%b lat=%0d want 1/1", o_err, o_lat); end
      n_cmp++; if (o_rdc !== 0 || o_acc !== 0) begin n_fail++; $display("FAIL misalign_bus: got reads=%0d acc=%0d want 0/0", o_rdc, o_acc); end
   endtask

   task automatic test_timeout;
      run32(1'b0, 2'd2, 1'b0, 32'h20, 32'h0, 5'd5, -1, 32'hCAFEF00D);
      n_cmp++; if (o_rdc !== TO) begin n_fail++; $display("FAIL to_reads: got %0d want %0d", o_rdc, TO); end
      n_cmp++; if (o_err !== 1'b1 || o_rdata !== 0 || o_lat !== TO + 1) begin n_fail++; $display("FAIL to_resp: got err=%b d=%h lat=%0d want 1/0/%0d", o_err, o_rdata, o_lat, TO + 1); end
      run32(1'b0, 2'd2, 1'b0, 32'h20, 32'h0, 5'd5, TO - 1, 32'hCAFEF00D);
      n_cmp++; if (o_err !== 1'b0 || o_rdata !== 32'hCAFEF00D) begin n_fail++; $display("FAIL to_lastack: got err=%b d=%h want 0/cafef00d", o_err, o_rdata); end
   endtask

   task automatic test_reset_mid_access;
      int seen;
      seen = 0;
      req_valid = 1; req_we = 0; req_size = 2'd2; req_addr = 32'h40; req_rd = 5'd9;
      @(posedge clk); #1;
      req_valid = 0;
      @(posedge clk); #1;
      n_cmp++; if (mem_read !== 1'b1) begin n_fail++; $display("FAIL rst_pre: got mem_read=%b want 1", mem_read); end
      #2 rst = 1;
      #1;
      n_cmp++; if (mem_read !== 1'b0 || req_ready !== 1'b1) begin n_fail++; $display("FAIL rst_async: got mem_read=%b ready=%b want 0/1", mem_read, req_ready); end
      @(negedge clk); rst = 0;
      mem_ack = 1;
      for (int i = 0; i < 8; i++) begin
         @(posedge clk); #1;
         if (resp_valid || mem_read) seen++;
      end
      mem_ack = 0;
      n_cmp++; if (seen !== 0) begin n_fail++; $display("FAIL rst_noresp: got %0d active cycles want 0", seen); end
   endtask

   task automatic test_dword;
      req_valid64 = 1; req_we64 = 0; req_size64 = 2'd3; req_unsigned64 = 1;
      req_addr64 = 32'h8; req_rd64 = 5'd9;
      mem_rdata64 = 64'hFEDCBA9876543210;
      @(posedge clk); #1;
      req_valid64 = 0;
      n_cmp++; if (mem_read64 !== 1'b1 || mem_addr64 !== 32'h8) begin n_fail++; $display("FAIL d64_bus: got rd=%b a=%h want 1/00000008", mem_read64, mem_addr64); end
      mem_ack64 = 1;
      @(posedge clk); #1;
      mem_ack64 = 0;
      n_cmp++; if (resp_valid64 !== 1'b1 || resp_rdata64 !== 64'hFEDCBA9876543210 || resp_err64 !== 1'b0) begin n_fail++; $display("FAIL d64_resp: got v=%b d=%h e=%b want 1/fedcba9876543210/0", resp_valid64, resp_rdata64, resp_err64); end
      @(posedge clk); #1;
      req_valid64 = 1; req_size64 = 2'd0; req_unsigned64 = 0; req_addr64 = 32'hD;
      @(posedge clk); #1;
      req_valid64 = 0;
      mem_ack64 = 1;
      @(posedge clk); #1;
      mem_ack64 = 0;
      n_cmp++; if (resp_rdata64 !== 64'hFFFFFFFFFFFFFFBA) begin n_fail++; $display("FAIL d64_lb: got %h want ffffffffffffffba", resp_rdata64); end
      @(posedge clk); #1;
      run32(1'b0, 2'd3, 1'b1, 32'h8, 32'h0, 5'd9, 0, 32'h76543210);
      n_cmp++; if (o_err !== 1'b1 || o_acc !== 0 || o_lat !== 1) begin n_fail++; $display("FAIL d32_illegal: got err=%b acc=%0d lat=%0d want 1/0/1", o_err, o_acc, o_lat); end
   endtask

   task automatic test_random;
      logic        we, uns, lg, tmo;
      logic [1:0]  size;
      logic [31:0] addr, wdata, mrd, e_rdata;
      logic [4:0]  rd;
      int          waits, r, e_lat, e_acc;
      for (int n = 0; n < 60; n++) begin
         we = 1'($urandom_range(0, 1)); uns = 1'($urandom_range(0, 1));
         size = 2'($urandom_range(0, 3));
         addr = $urandom; wdata = $urandom; mrd = $urandom; rd = 5'($urandom);
         if ($urandom_range(0, 3) != 0) addr = addr & ~((32'd1 << size) - 32'd1);
         r = $urandom_range(0, 9);
         waits = (r == 9) ? -1 : r % 5;
         run32(we, size, uns, addr, wdata, rd, waits, mrd);
         lg  = legal32(size, addr);
         tmo = (waits < 0) || (waits >= TO);
         e_lat = !lg ? 1 : (tmo ? TO + 1 : waits + 2);
         e_acc = !lg ? 0 : (tmo ? TO : waits + 1);
         e_rdata = (!lg || tmo || we) ? 32'h0 : exp_load(mrd, addr, size, uns);
         n_cmp++; if (o_lat !== e_lat) begin n_fail++; $display("FAIL rnd_lat[%0d]: got %0d want %0d", n, o_lat, e_lat); end
         n_cmp++; if (o_err !== (!lg || tmo)) begin n_fail++; $display("FAIL rnd_err[%0d]: got %b want %b", n, o_err, (!lg || tmo)); end
         n_cmp++; if (o_rdata !== e_rdata) begin n_fail++; $display("FAIL rnd_rdata[%0d]: got %h want %h", n, o_rdata, e_rdata); end
         n_cmp++; if (o_rd !== (we ? 5'd0 : rd)) begin n_fail++; $display("FAIL rnd_rd[%0d]: got %0d want %0d", n, o_rd, (we ? 5'd0 : rd)); end
         n_cmp++; if (o_acc !== e_acc || o_rdc !== (we ? 0 : e_acc)) begin n_fail++; $display("FAIL rnd_acc[%0d]: got acc=%0d reads=%0d want %0d", n, o_acc, o_rdc, e_acc); end
         n_cmp++; if (o_quiet !== 1'b1 || o_pulse !== 1'b1 || o_stable !== 1'b1) begin n_fail++; $display("FAIL rnd_proto[%0d]: got quiet=%b pulse=%b stable=%b want 1/1/1", n, o_quiet, o_pulse, o_stable); end
         if (lg) begin
            n_cmp++; if (o_addr !== (addr & ~32'h3)) begin n_fail++; $display("FAIL rnd_addr[%0d]: got %h want %h", n, o_addr, addr & ~32'h3); end
            if (we) begin
               n_cmp++; if (o_strobe !== 4'(((32'd1 << (32'd1 << size)) - 32'd1) << (addr % 4))) begin n_fail++; $display("FAIL rnd_strobe[%0d]: got %b size=%0d addr=%h", n, o_strobe, size, addr); end
               n_cmp++; if (o_wdata !== 32'(64'(wdata) << (8 * (addr % 4)))) begin n_fail++; $display("FAIL rnd_wdata[%0d]: got %h want %h", n, o_wdata, 32'(64'(wdata) << (8 * (addr % 4)))); end
            end
         end
      end
   endtask

   initial begin
      test_reset();
      test_load_byte();
      test_store_half();
      test_misaligned();
      test_timeout();
      test_reset_mid_access();
      test_dword();
      test_random();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule
